// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central sequencing controller for the 5-stage MIPS pipeline.
// Drives the register enables and flushes of IF/ID, ID/EX, EX/MEM and MEM/WB,
// PC write enable and select, branch-predictor updates and the halt-drain FSM.
// Event priority: data wait > halt entry > mispredict > load-use > fetch miss > normal.
// Optional performance counters are built when the macro PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl #(
  parameter int IDX_W = 3
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_memrd,
  input  logic             exmem_memwr,
  input  logic [1:0]       exmem_bra,
  input  logic             exmem_zero,
  input  logic             exmem_predict,
  input  logic [IDX_W-1:0] exmem_index,
  input  logic             exmem_halt,
  input  logic             idex_memrd,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_valid,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             bp_wen,
  output logic [IDX_W-1:0] bp_index,
  output logic             bp_taken,
  output logic             halt,
  output logic             imemren
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] cyc_cnt
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
  , output logic [CNT_W-1:0] mispred_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_TARGET = 2'b01;
  localparam logic [1:0] SEL_FALL   = 2'b10;

  state_e state_q, state_d;
  logic   halt_q, halt_d;
  logic   redir_q, redir_d;

  logic dstall;
  logic taken;
  logic mispred;
  logic loadUse;

  logic       pcEnC;
  logic [1:0] pcSelC;
  logic       ifidEnC, idexEnC, exmemEnC, memwbEnC;
  logic       ifidFlushC, idexFlushC, exmemFlushC;
  logic       bpWenC;
  logic       imemrenC;

  // Hazard detection terms shared by the sequencing logic.
  always_comb begin
    dstall  = (exmem_memrd | exmem_memwr) & ~dhit;
    taken   = ((exmem_bra == 2'b10) & exmem_zero) |
              ((exmem_bra == 2'b01) & ~exmem_zero);
    mispred = (exmem_bra != 2'b00) & (taken != exmem_predict);
    loadUse = idex_memrd & (idex_rt != 5'd0) & ifid_valid &
              ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
  end

  // Next-state and prioritised pipeline control for the current cycle.
  always_comb begin
    state_d     = state_q;
    halt_d      = halt_q;
    redir_d     = redir_q;
    pcEnC       = 1'b0;
    pcSelC      = SEL_SEQ;
    ifidEnC     = 1'b1;
    idexEnC     = 1'b1;
    exmemEnC    = 1'b1;
    memwbEnC    = 1'b1;
    ifidFlushC  = 1'b0;
    idexFlushC  = 1'b0;
    exmemFlushC = 1'b0;
    bpWenC      = 1'b0;
    imemrenC    = 1'b1;

    case (state_q)
      RUN: begin
        if (dstall) begin
          ifidEnC  = 1'b0;
          idexEnC  = 1'b0;
          exmemEnC = 1'b0;
          memwbEnC = 1'b0;
        end else if (exmem_halt) begin
          imemrenC    = 1'b0;
          ifidFlushC  = 1'b1;
          idexFlushC  = 1'b1;
          exmemFlushC = 1'b1;
          redir_d     = 1'b0;
          state_d     = DRAIN;
        end else begin
          bpWenC = (exmem_bra != 2'b00);
          if (mispred) begin
            pcEnC       = 1'b1;
            pcSelC      = taken ? SEL_TARGET : SEL_FALL;
            ifidFlushC  = 1'b1;
            idexFlushC  = 1'b1;
            exmemFlushC = 1'b1;
            redir_d     = ~ihit;
          end else if (loadUse) begin
            ifidEnC    = 1'b0;
            idexFlushC = 1'b1;
          end else if (~ihit) begin
            ifidFlushC = 1'b1;
          end else if (redir_q) begin
            ifidFlushC = 1'b1;
            redir_d    = 1'b0;
          end else begin
            pcEnC = 1'b1;
          end
        end
      end
      DRAIN: begin
        ifidEnC  = 1'b0;
        idexEnC  = 1'b0;
        exmemEnC = 1'b0;
        memwbEnC = 1'b0;
        imemrenC = 1'b0;
        halt_d   = 1'b1;
        state_d  = HALTED;
      end
      HALTED: begin
        ifidEnC  = 1'b0;
        idexEnC  = 1'b0;
        exmemEnC = 1'b0;
        memwbEnC = 1'b0;
        imemrenC = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // While reset is held the pipeline registers are enabled with no flush or update.
  always_comb begin
    pc_en       = nRST & pcEnC;
    pc_sel      = nRST ? pcSelC : SEL_SEQ;
    ifid_en     = ~nRST | ifidEnC;
    idex_en     = ~nRST | idexEnC;
    exmem_en    = ~nRST | exmemEnC;
    memwb_en    = ~nRST | memwbEnC;
    ifid_flush  = nRST & ifidFlushC;
    idex_flush  = nRST & idexFlushC;
    exmem_flush = nRST & exmemFlushC;
    bp_wen      = nRST & bpWenC;
    bp_index    = exmem_index;
    bp_taken    = taken;
    imemren     = ~nRST | imemrenC;
    halt        = halt_q;
  end

  // FSM state, sticky halt flag and pending-redirect flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
      redir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      redir_q <= redir_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic runCycle, stallEvent, flushEvent, mispredEvent;

  // Classify the current cycle for the performance counters.
  always_comb begin
    runCycle     = (state_q == RUN);
    stallEvent   = dstall | (~exmem_halt & ~mispred & (loadUse | ~ihit));
    flushEvent   = ifidFlushC | idexFlushC | exmemFlushC;
    mispredEvent = ~dstall & ~exmem_halt & mispred;
  end

  // Saturating counters that only advance while the pipeline is running.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cyc_cnt     <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mispred_cnt <= '0;
    end else if (runCycle) begin
      if (cyc_cnt != '1)
        cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (stallEvent && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flushEvent && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (mispredEvent && mispred_cnt != '1)
        mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl (default build).
module tb_pipeline_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, exmem_memrd, exmem_memwr;
  logic [1:0] exmem_bra;
  logic       exmem_zero, exmem_predict;
  logic [2:0] exmem_index;
  logic       exmem_halt, idex_memrd;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       ifid_valid;

  logic       pc_en;
  logic [1:0] pc_sel;
  logic       ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush;
  logic       bp_wen;
  logic [2:0] bp_index;
  logic       bp_taken;
  logic       halt;
  logic       imemren;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       ihit;
    logic       dhit;
    logic       exmem_memrd;
    logic       exmem_memwr;
    logic [1:0] exmem_bra;
    logic       exmem_zero;
    logic       exmem_predict;
    logic [2:0] exmem_index;
    logic       exmem_halt;
    logic       idex_memrd;
    logic [4:0] idex_rt;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       ifid_valid;
  } stim_t;

  pipeline_ctrl #(.IDX_W(3)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_memrd(exmem_memrd), .exmem_memwr(exmem_memwr),
    .exmem_bra(exmem_bra), .exmem_zero(exmem_zero),
    .exmem_predict(exmem_predict), .exmem_index(exmem_index),
    .exmem_halt(exmem_halt), .idex_memrd(idex_memrd), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_valid(ifid_valid),
    .pc_en(pc_en), .pc_sel(pc_sel),
    .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .bp_wen(bp_wen), .bp_index(bp_index), .bp_taken(bp_taken),
    .halt(halt), .imemren(imemren)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 CLK = ~CLK;

  function automatic stim_t idleStim();
    stim_t s;
    s      = '0;
    s.ihit = 1'b1;
    s.dhit = 1'b1;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    ihit          = s.ihit;
    dhit          = s.dhit;
    exmem_memrd   = s.exmem_memrd;
    exmem_memwr   = s.exmem_memwr;
    exmem_bra     = s.exmem_bra;
    exmem_zero    = s.exmem_zero;
    exmem_predict = s.exmem_predict;
    exmem_index   = s.exmem_index;
    exmem_halt    = s.exmem_halt;
    idex_memrd    = s.idex_memrd;
    idex_rt       = s.idex_rt;
    ifid_rs       = s.ifid_rs;
    ifid_rt       = s.ifid_rt;
    ifid_valid    = s.ifid_valid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ens();
    return {28'd0, ifid_en, idex_en, exmem_en, memwb_en};
  endfunction

  function automatic logic [31:0] fls();
    return {29'd0, ifid_flush, idex_flush, exmem_flush};
  endfunction

  // Inputs change at falling edges; outputs are sampled 2 time units later.
  initial begin
    stim_t s;
    nRST = 1'b0;
    applyStimulus('0);
    #2;
    checkOutput("reset_pc_en", {31'd0, pc_en}, 32'd0);
    checkOutput("reset_en", ens(), 32'hF);
    checkOutput("reset_flush", fls(), 32'd0);
    checkOutput("reset_bp_wen", {31'd0, bp_wen}, 32'd0);
    checkOutput("reset_imemren", {31'd0, imemren}, 32'd1);
    checkOutput("reset_halt", {31'd0, halt}, 32'd0);

    @(negedge CLK);
    nRST = 1'b1;
    applyStimulus(idleStim());
    #2;
    checkOutput("normal_pc_en", {31'd0, pc_en}, 32'd1);
    checkOutput("normal_pc_sel", {30'd0, pc_sel}, 32'd0);
    checkOutput("normal_en", ens(), 32'hF);
    checkOutput("normal_flush", fls(), 32'd0);

    // Load-use hazard on rs
    @(negedge CLK);
    s = idleStim();
    s.idex_memrd = 1'b1; s.idex_rt = 5'd5; s.ifid_rs = 5'd5; s.ifid_valid = 1'b1;
    applyStimulus(s);
    #2;
    checkOutput("lu_pc_en", {31'd0, pc_en}, 32'd0);
    checkOutput("lu_en", ens(), 32'h7);
    checkOutput("lu_flush", fls(), 32'h2);
    @(negedge CLK);
    applyStimulus(idleStim());
    #2;
    checkOutput("lu_after_pc_en", {31'd0, pc_en}, 32'd1);
    checkOutput("lu_after_flush", fls(), 32'd0);

    // Load-use on rt matches; load into r0 and a bubble in ID never stall
    @(negedge CLK);
    s = idleStim();
    s.idex_memrd = 1'b1; s.idex_rt = 5'd9; s.ifid_rt = 5'd9; s.ifid_valid = 1'b1;
    applyStimulus(s);
    #2;
    checkOutput("lu_rt_en", ens(), 32'h7);
    @(negedge CLK);
    s.idex_rt = 5'd0; s.ifid_rt = 5'd0;
    applyStimulus(s);
    #2;
    checkOutput("lu_r0_pc_en", {31'd0, pc_en}, 32'd1);
    @(negedge CLK);
    s.idex_rt = 5'd9; s.ifid_rt = 5'd9; s.ifid_valid = 1'b0;
    applyStimulus(s);
    #2;
    checkOutput("lu_bubble_pc_en", {31'd0, pc_en}, 32'd1);

    // BEQ taken, predicted not taken
    @(negedge CLK);
    s = idleStim();
    s.exmem_bra = 2'b10; s.exmem_zero = 1'b1; s.exmem_predict = 1'b0; s.exmem_index = 3'd3;
    applyStimulus(s);
    #2;
    checkOutput("mp_pc_sel", {30'd0, pc_sel}, 32'd1);
    checkOutput("mp_pc_en", {31'd0, pc_en}, 32'd1);
    checkOutput("mp_flush", fls(), 32'h7);
    checkOutput("mp_en", ens(), 32'hF);
    checkOutput("mp_bp_wen", {31'd0, bp_wen}, 32'd1);
    checkOutput("mp_bp_index", {29'd0, bp_index}, 32'd3);
    checkOutput("mp_bp_taken", {31'd0, bp_taken}, 32'd1);

    // Correctly predicted branch still updates the predictor
    @(negedge CLK);
    s.exmem_predict = 1'b1; s.exmem_index = 3'd6;
    applyStimulus(s);
    #2;
    checkOutput("ok_flush", fls(), 32'd0);
    checkOutput("ok_bp_wen", {31'd0, bp_wen}, 32'd1);
    checkOutput("ok_bp_index", {29'd0, bp_index}, 32'd6);

    // Mispredict outranks a simultaneous load-use
    @(negedge CLK);
    s = idleStim();
    s.exmem_bra = 2'b10; s.exmem_zero = 1'b1;
    s.idex_memrd = 1'b1; s.idex_rt = 5'd4; s.ifid_rs = 5'd4; s.ifid_valid = 1'b1;
    applyStimulus(s);
    #2;
    checkOutput("mp_lu_en", ens(), 32'hF);
    checkOutput("mp_lu_flush", fls(), 32'h7);

    // Data wait over a BNE not-taken that was predicted taken
    s = idleStim();
    s.exmem_memrd = 1'b1; s.dhit = 1'b0;
    s.exmem_bra = 2'b01; s.exmem_zero = 1'b1; s.exmem_predict = 1'b1; s.exmem_index = 3'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      applyStimulus(s);
      #2;
      checkOutput("dw_en", ens(), 32'd0);
      checkOutput("dw_pc_en", {31'd0, pc_en}, 32'd0);
      checkOutput("dw_bp_wen", {31'd0, bp_wen}, 32'd0);
      checkOutput("dw_flush", fls(), 32'd0);
    end
    @(negedge CLK);
    s.dhit = 1'b1;
    applyStimulus(s);
    #2;
    checkOutput("dw_done_pc_sel", {30'd0, pc_sel}, 32'd2);
    checkOutput("dw_done_bp_taken", {31'd0, bp_taken}, 32'd0);
    checkOutput("dw_done_bp_wen", {31'd0, bp_wen}, 32'd1);

    // Mispredict while the fetch is outstanding, then two more miss cycles
    @(negedge CLK);
    s = idleStim();
    s.ihit = 1'b0; s.exmem_bra = 2'b10; s.exmem_zero = 1'b0; s.exmem_predict = 1'b1;
    applyStimulus(s);
    #2;
    checkOutput("rd_mp_pc_sel", {30'd0, pc_sel}, 32'd2);
    checkOutput("rd_mp_pc_en", {31'd0, pc_en}, 32'd1);
    s = idleStim();
    s.ihit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      applyStimulus(s);
      #2;
      checkOutput("rd_miss_pc_en", {31'd0, pc_en}, 32'd0);
      checkOutput("rd_miss_flush", fls(), 32'h4);
      checkOutput("rd_miss_en", ens(), 32'hF);
    end
    @(negedge CLK);
    applyStimulus(idleStim());
    #2;
    checkOutput("rd_hit_flush", fls(), 32'h4);
    checkOutput("rd_hit_pc_en", {31'd0, pc_en}, 32'd0);
    @(negedge CLK);
    #2;
    checkOutput("rd_clear_flush", fls(), 32'd0);
    checkOutput("rd_clear_pc_en", {31'd0, pc_en}, 32'd1);

    // Pending redirect is wiped by reset
    @(negedge CLK);
    s = idleStim();
    s.ihit = 1'b0; s.exmem_bra = 2'b10; s.exmem_zero = 1'b1;
    applyStimulus(s);
    @(negedge CLK);
    applyStimulus(idleStim());
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    #2;
    checkOutput("rd_reset_flush", fls(), 32'd0);
    checkOutput("rd_reset_pc_en", {31'd0, pc_en}, 32'd1);

    // Halt entry, one drain cycle, then sticky halt
    @(negedge CLK);
    s = idleStim();
    s.exmem_halt = 1'b1;
    applyStimulus(s);
    #2;
    checkOutput("h_entry_imemren", {31'd0, imemren}, 32'd0);
    checkOutput("h_entry_pc_en", {31'd0, pc_en}, 32'd0);
    checkOutput("h_entry_flush", fls(), 32'h7);
    checkOutput("h_entry_en", ens(), 32'hF);
    @(negedge CLK);
    applyStimulus(idleStim());
    #2;
    checkOutput("h_drain_halt", {31'd0, halt}, 32'd0);
    checkOutput("h_drain_imemren", {31'd0, imemren}, 32'd0);
    checkOutput("h_drain_en", ens(), 32'd0);
    @(negedge CLK);
    #2;
    checkOutput("h_halted_halt", {31'd0, halt}, 32'd1);
    checkOutput("h_halted_imemren", {31'd0, imemren}, 32'd0);
    checkOutput("h_halted_pc_en", {31'd0, pc_en}, 32'd0);
    checkOutput("h_halted_en", ens(), 32'd0);
    @(negedge CLK);
    #2;
    checkOutput("h_held_halt", {31'd0, halt}, 32'd1);
    nRST = 1'b0;
    #1;
    checkOutput("h_reset_halt", {31'd0, halt}, 32'd0);
    checkOutput("h_reset_imemren", {31'd0, imemren}, 32'd1);
    @(negedge CLK);
    nRST = 1'b1;

    // Halt coinciding with mispredict: halt wins, then reset mid-drain
    s = idleStim();
    s.exmem_halt = 1'b1; s.exmem_bra = 2'b10; s.exmem_zero = 1'b1; s.exmem_predict = 1'b0;
    applyStimulus(s);
    #2;
    checkOutput("hm_pc_sel", {30'd0, pc_sel}, 32'd0);
    checkOutput("hm_pc_en", {31'd0, pc_en}, 32'd0);
    checkOutput("hm_bp_wen", {31'd0, bp_wen}, 32'd0);
    @(negedge CLK);
    applyStimulus(idleStim());
    #2;
    checkOutput("hm_drain_imemren", {31'd0, imemren}, 32'd0);
    nRST = 1'b0;
    #1;
    checkOutput("hm_reset_halt", {31'd0, halt}, 32'd0);
    checkOutput("hm_reset_imemren", {31'd0, imemren}, 32'd1);
    @(negedge CLK);
    nRST = 1'b1;
    #2;
    checkOutput("hm_run_pc_en", {31'd0, pc_en}, 32'd1);
    @(negedge CLK);
    #2;
    checkOutput("hm_run_halt", {31'd0, halt}, 32'd0);
    checkOutput("hm_run_imemren", {31'd0, imemren}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
